i2c_accel_target: RTL and testbench
===================================

# i2c_accel_target

I2C target (slave) that emulates the accelerometer register map on the FPGA side of the I2C bus. It decodes START/STOP, matches its 7-bit device address, and serves register writes (pointer + data, auto-increment) and combined-format reads (write pointer, repeated START, multi-byte read). It drives SDA open-drain only. The fabric loads sample data through a host write port. It is the bench/loopback counterpart for the I2C master state machine and a standalone sensor model for board bring-up.

## Interface
- DEV_ADDR, 7'h53, 7-bit device address answered (write 0xA6, read 0xA7)
- DEVID, 8'hE5, read-only contents of register 0x00
- clk  in  1  system clock (50 MHz); the only clock
- reset  in  1  asynchronous, active-high
- scl_in  in  1  bus SCL, asynchronous to clk
- sda_in  in  1  bus SDA, asynchronous to clk
- sda_oe  out  1  1 = pull SDA low, 0 = release; top level ties SDA pad to 0 when sda_oe is high, else Z
- host_we  in  1  fabric write strobe into register file
- host_addr  in  6  fabric write address
- host_wdata  in  8  fabric write data
- wr_strobe  out  1  one-clk pulse per register byte committed from the bus
- wr_addr  out  6  register address of that byte, valid with wr_strobe
- wr_data  out  8  data of that byte, valid with wr_strobe
- busy  out  1  high from an address-matched START until STOP or NACKed address

## Operation
- Register file: 64 x 8, addresses 0x00-0x3F. Register 0x00 reads DEVID and ignores writes. Pointer ptr is 6 bits and wraps from 0x3F to 0x00.
- SCL and SDA pass through 2-flop synchronizers. Edge and condition detection runs on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are honoured in every state.
- SDA is sampled on SCL rising edges, MSB first. sda_oe changes only on SCL falling edges, except on START, STOP and reset, which release SDA immediately.
- States:
  - IDLE: waits for START, then goes to ADDR.
  - ADDR: shifts in 8 bits. If bits[7:1] == DEV_ADDR, goes to ADDR_ACK. Otherwise goes to WAIT_STOP with SDA released and busy low.
  - ADDR_ACK: sets busy and drives sda_oe=1 for one SCL period. If R/W=0, goes to WR_BYTE with first_byte=1. If R/W=1, goes to RD_BYTE.
  - WR_BYTE: shifts in 8 bits. If first_byte, loads ptr. Otherwise writes regs[ptr] (skipped for 0x00), pulses wr_strobe, then ptr++. Then goes to WR_ACK.
  - WR_ACK: drives sda_oe=1 for one SCL period (every byte is ACKed), clears first_byte, returns to WR_BYTE.
  - RD_BYTE: on the SCL falling edge that ends the preceding ACK, loads shift register from regs[ptr] and does ptr++. Drives sda_oe = ~bit for 8 bits, then releases SDA and goes to RD_ACK.
  - RD_ACK: samples SDA on SCL rising. 0 (ACK) goes to RD_BYTE. 1 (NACK) goes to WAIT_STOP.
  - WAIT_STOP: SDA released. STOP goes to IDLE; START goes to ADDR.
- Repeated START from any state: go to ADDR, release SDA, keep ptr.
- STOP from any state: go to IDLE, release SDA, clear busy, keep ptr.
- Host/bus write collision in the same clk:
  - Same address: the bus write wins.
  - Different addresses: both writes take effect.
  - host_we to 0x00 is ignored.

## Timing
- Reset values: sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, ptr=0, state=IDLE, all registers 0x00 except register 0x00 = DEVID.
- Detection latency: 3 clk from pin edge to internal edge pulse (2 sync + 1 edge register).
- sda_oe updates in the clk after the detected SCL falling edge, i.e. 4 clk after the pin edge.
- Bus requirements: SCL high and low phases ≥ 6 clk. SDA setup/hold around SCL edges ≥ 4 clk. 100 kHz and 400 kHz at 50 MHz meet this.
- wr_strobe: high exactly one clk, in the clk after the detected 8th rising edge of a data byte. The register holds the new value from the next clk.
- A host write is visible in the following clk. A read captures regs[ptr] at the load instant; later host writes do not alter a byte already being shifted.

## Test plan
- Reset, then read: 0xA6, 0x00, Sr, 0xA7, read 1 byte, NACK, P -> address, pointer and START all ACKed, data 0xE5, sda_oe=0 after P, busy low.
- Write 0xA6, 0x31, 0x0B, 0x08, P -> two wr_strobe pulses: (0x31,0x0B) then (0x32,0x08). Read-back from 0x31 gives 0x0B, 0x08.
- Host writes 0x32..0x37 = 0x11..0x66, then read 6 bytes from 0x32 with ACK, ACK, ACK, ACK, ACK, NACK -> 0x11..0x66, SDA released after the 6th byte.
- Address 0x3A (write 0x74) -> no ACK (SDA stays high on the 9th clock), busy stays 0, no wr_strobe.
- Read 3 bytes starting at 0x3F -> regs[0x3F], 0xE5, regs[0x01] (wrap). Write to 0x00 is ACKed, produces no strobe, and DEVID is unchanged.
- Assert reset during a read byte with SDA driven low -> sda_oe=0 immediately. A STOP mid-byte on a separate run -> IDLE, busy=0.

Source files
------------

// File: rtl/i2c_accel_target.sv
// i2c_accel_target: I2C target emulating an accelerometer register map.
// Decodes START/STOP, answers DEV_ADDR, and serves pointer+data writes with
// auto-increment and combined-format multi-byte reads. SDA is open-drain.
// Ports:
//   clk, reset           system clock, async active-high reset
//   scl_in, sda_in       raw bus lines (asynchronous to clk)
//   sda_oe               1 = pull SDA low, 0 = release
//   host_we/addr/wdata   fabric write port into the register file
//   wr_strobe/addr/data  one-clk report of each byte committed from the bus
//   busy                 address-matched transaction in progress
module i2c_accel_target #(
    parameter logic [6:0] DEV_ADDR = 7'h53,
    parameter logic [7:0] DEVID    = 8'hE5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       host_we,
    input  logic [5:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int unsigned AW   = 6;
    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 64;
    localparam int unsigned CW   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    // Synchronizers and registered edge / bus-condition pulses.
    // Flops reset to 1 so an idle bus does not look like an edge after reset.
    logic scl_m, scl_s, scl_q;
    logic sda_m, sda_s, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_m     <= 1'b1;
            scl_s     <= 1'b1;
            scl_q     <= 1'b1;
            sda_m     <= 1'b1;
            sda_s     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_bit   <= 1'b1;
        end else begin
            scl_m     <= scl_in;
            scl_s     <= scl_m;
            scl_q     <= scl_s;
            sda_m     <= sda_in;
            sda_s     <= sda_m;
            sda_q     <= sda_s;
            scl_rise  <= scl_s & ~scl_q;
            scl_fall  <= ~scl_s & scl_q;
            start_det <= scl_s & scl_q & sda_q & ~sda_s;
            stop_det  <= scl_s & scl_q & ~sda_q & sda_s;
            sda_bit   <= sda_s;
        end
    end

    // FSM and datapath registers
    state_t          state, state_n;
    logic [DW-1:0]   shreg, shreg_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [AW-1:0]   ptr, ptr_n;
    logic            first_byte, first_n;
    logic            ack_end, ack_end_n;   // next SCL fall ends an ACK slot
    logic            rd_mode, rd_n;
    logic            sda_oe_n, busy_n, wr_strobe_n;
    logic [AW-1:0]   wr_addr_n;
    logic [DW-1:0]   wr_data_n;
    logic            bus_we;
    logic [DW-1:0]   byte_in;
    logic [DW-1:0]   rd_byte;
    logic [DW-1:0]   regs [NREG];

    assign byte_in = {shreg[6:0], sda_bit};
    // Register 0 holds DEVID and is never written, so a plain read suffices.
    assign rd_byte = regs[ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ptr        <= '0;
            first_byte <= 1'b0;
            ack_end    <= 1'b0;
            rd_mode    <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            first_byte <= first_n;
            ack_end    <= ack_end_n;
            rd_mode    <= rd_n;
            sda_oe     <= sda_oe_n;
            busy       <= busy_n;
            wr_strobe  <= wr_strobe_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
        end
    end

    // Next-state / output logic. ACK states drive SDA on the SCL fall and
    // hand over on the following rise; the fall after that ends the ACK slot.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        cnt_n       = cnt;
        ptr_n       = ptr;
        first_n     = first_byte;
        ack_end_n   = ack_end;
        rd_n        = rd_mode;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        wr_strobe_n = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        bus_we      = 1'b0;

        if (stop_det) begin
            state_n   = S_IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            ack_end_n = 1'b0;
            cnt_n     = '0;
        end else if (start_det) begin
            state_n   = S_ADDR;
            sda_oe_n  = 1'b0;
            ack_end_n = 1'b0;
            cnt_n     = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + CW'(1);
                        if (cnt == CW'(7)) begin
                            cnt_n = '0;
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_n = S_ADDR_ACK;
                                busy_n  = 1'b1;
                                rd_n    = byte_in[0];
                            end else begin
                                state_n  = S_WAIT_STOP;
                                busy_n   = 1'b0;
                                sda_oe_n = 1'b0;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b1;
                    end else if (scl_rise) begin
                        state_n   = rd_mode ? S_RD_BYTE : S_WR_BYTE;
                        ack_end_n = 1'b1;
                        first_n   = 1'b1;
                        cnt_n     = '0;
                    end
                end
                S_WR_BYTE: begin
                    if (scl_fall && ack_end) begin
                        sda_oe_n  = 1'b0;
                        ack_end_n = 1'b0;
                    end else if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + CW'(1);
                        if (cnt == CW'(7)) begin
                            cnt_n   = '0;
                            state_n = S_WR_ACK;
                            if (first_byte) begin
                                ptr_n = byte_in[AW-1:0];
                            end else begin
                                // Register 0 is read-only: ACKed but not committed.
                                if (ptr != '0) begin
                                    bus_we      = 1'b1;
                                    wr_strobe_n = 1'b1;
                                    wr_addr_n   = ptr;
                                    wr_data_n   = byte_in;
                                end
                                ptr_n = ptr + AW'(1);
                            end
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b1;
                    end else if (scl_rise) begin
                        state_n   = S_WR_BYTE;
                        ack_end_n = 1'b1;
                        first_n   = 1'b0;
                    end
                end
                S_RD_BYTE: begin
                    if (scl_fall) begin
                        if (ack_end) begin
                            // Byte is captured here; later host writes cannot alter it.
                            shreg_n   = rd_byte;
                            sda_oe_n  = ~rd_byte[7];
                            ptr_n     = ptr + AW'(1);
                            cnt_n     = '0;
                            ack_end_n = 1'b0;
                        end else if (cnt == CW'(8)) begin
                            sda_oe_n = 1'b0;
                            state_n  = S_RD_ACK;
                            cnt_n    = '0;
                        end else begin
                            shreg_n  = {shreg[6:0], 1'b0};
                            sda_oe_n = ~shreg[6];
                        end
                    end else if (scl_rise && !ack_end) begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_bit) begin
                            state_n   = S_RD_BYTE;
                            ack_end_n = 1'b1;
                        end else begin
                            state_n = S_WAIT_STOP;
                        end
                    end
                end
                S_WAIT_STOP: begin
                    sda_oe_n = 1'b0;
                end
                default: begin
                    state_n  = S_IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    // Register file; on a same-address collision the bus write is last and wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            regs[0] <= DEVID;
        end else begin
            if (host_we && host_addr != '0) begin
                regs[host_addr] <= host_wdata;
            end
            if (bus_we) begin
                regs[ptr] <= byte_in;
            end
        end
    end

endmodule

// File: tb/tb_i2c_accel_target.sv
// Self-checking bench for i2c_accel_target: bit-banged I2C master, open-drain
// SDA wiring, and a register-map reference model (array + pointer).
module tb_i2c_accel_target;

    localparam int Q = 5;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_in, sda_in, sda_oe;
    logic       host_we = 1'b0;
    logic [5:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe;

    always #10 clk = ~clk;

    i2c_accel_target dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    logic [7:0] mregs [64];
    logic [5:0] mptr;
    logic [13:0] sq[$];    // observed strobes {addr,data}
    logic [13:0] esq[$];   // expected strobes
    logic [7:0]  wq[$];    // bytes to write
    logic [7:0]  rq[$];    // bytes read
    logic [7:0]  erq[$];   // expected read bytes
    logic        busy_mid, oe_before_stop;

    always @(negedge clk) begin
        if (!reset && wr_strobe) sq.push_back({wr_addr, wr_data});
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
        mregs[0] = 8'hE5;
        mptr = 6'd0;
    endtask

    task automatic model_write(input logic [5:0] p);
        esq.delete();
        mptr = p;
        foreach (wq[i]) begin
            if (mptr != 0) begin
                mregs[mptr] = wq[i];
                esq.push_back({mptr, wq[i]});
            end
            mptr = mptr + 6'd1;
        end
    endtask

    task automatic model_read(input bit setptr, input logic [5:0] p, input int n);
        erq.delete();
        if (setptr) mptr = p;
        for (int i = 0; i < n; i++) begin
            erq.push_back(mregs[mptr]);
            mptr = mptr + 6'd1;
        end
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        wclk(1);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        wclk(1);
        host_we = 1'b0;
        if (a != 0) mregs[a] = d;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        m_sda = 1'b1; wclk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; wclk(Q);
        m_scl = 1'b1; wclk(2 * Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    // Optional host write lands on the same clk as the bus commit of this byte.
    task automatic write_byte(input logic [7:0] b, input bit coll, input logic [5:0] ha,
                              input logic [7:0] hd, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; wclk(Q);
            m_scl = 1'b1;
            if (coll && i == 0) begin
                wclk(3);
                host_we = 1'b1; host_addr = ha; host_wdata = hd;
                wclk(1);
                host_we = 1'b0;
                wclk(2 * Q - 4);
            end else begin
                wclk(2 * Q);
            end
            m_scl = 1'b0; wclk(Q);
        end
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(Q);
        ack = sda_in; wclk(Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic read_byte(input bit nack, output logic [7:0] d);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wclk(Q); m_scl = 1'b1;
            wclk(Q); d[i] = sda_in;
            wclk(Q); m_scl = 1'b0;
            wclk(Q);
        end
        m_sda = nack; wclk(Q);
        m_scl = 1'b1; wclk(2 * Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic bus_write(input logic [5:0] p, output bit ok);
        logic a;
        ok = 1'b1;
        sq.delete();
        i2c_start();
        write_byte(8'hA6, 1'b0, 6'd0, 8'd0, a); if (a !== 1'b0) ok = 1'b0;
        write_byte({2'b00, p}, 1'b0, 6'd0, 8'd0, a); if (a !== 1'b0) ok = 1'b0;
        foreach (wq[i]) begin
            write_byte(wq[i], 1'b0, 6'd0, 8'd0, a); if (a !== 1'b0) ok = 1'b0;
        end
        i2c_stop();
    endtask

    task automatic bus_read(input bit setptr, input logic [5:0] p, input int n, output bit ok);
        logic a;
        logic [7:0] d;
        ok = 1'b1;
        rq.delete();
        i2c_start();
        if (setptr) begin
            write_byte(8'hA6, 1'b0, 6'd0, 8'd0, a); if (a !== 1'b0) ok = 1'b0;
            write_byte({2'b00, p}, 1'b0, 6'd0, 8'd0, a); if (a !== 1'b0) ok = 1'b0;
            i2c_start();
        end
        write_byte(8'hA7, 1'b0, 6'd0, 8'd0, a); if (a !== 1'b0) ok = 1'b0;
        busy_mid = busy;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            rq.push_back(d);
        end
        oe_before_stop = sda_oe;
        i2c_stop();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wclk(3);
        n_cmp += 5;
        if (sda_oe !== 1'b0)    begin n_bad++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (wr_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
        if (wr_addr !== 6'h00)  begin n_bad++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        if (wr_data !== 8'h00)  begin n_bad++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        reset = 1'b0;
        model_reset();
        wclk(5);
    endtask

    task automatic test_devid_read();
        bit ok;
        model_read(1'b1, 6'h00, 1);
        bus_read(1'b1, 6'h00, 1, ok);
        n_cmp += 5;
        if (ok !== 1'b1)        begin n_bad++; $display("FAIL devid_acks got %b want 1", ok); end
        if (busy_mid !== 1'b1)  begin n_bad++; $display("FAIL devid_busy_mid got %b want 1", busy_mid); end
        if (rq[0] !== 8'hE5)    begin n_bad++; $display("FAIL devid_data got %h want e5", rq[0]); end
        if (sda_oe !== 1'b0)    begin n_bad++; $display("FAIL devid_sda_oe_after_p got %b want 0", sda_oe); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL devid_busy_after_p got %b want 0", busy); end
    endtask

    task automatic test_write_strobes();
        bit ok;
        wq = '{8'h0B, 8'h08};
        model_write(6'h31);
        bus_write(6'h31, ok);
        n_cmp += 2;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_acks got %b want 1", ok); end
        if (sq.size() != esq.size()) begin
            n_bad++; $display("FAIL wr_strobe_count got %0d want %0d", sq.size(), esq.size());
        end else begin
            foreach (esq[i]) begin
                n_cmp++;
                if (sq[i] !== esq[i]) begin n_bad++; $display("FAIL wr_strobe_%0d got %h want %h", i, sq[i], esq[i]); end
            end
        end
        model_read(1'b1, 6'h31, 2);
        bus_read(1'b1, 6'h31, 2, ok);
        foreach (erq[i]) begin
            n_cmp++;
            if (rq[i] !== erq[i]) begin n_bad++; $display("FAIL wr_readback_%0d got %h want %h", i, rq[i], erq[i]); end
        end
    endtask

    task automatic test_host_burst();
        bit ok;
        for (int i = 0; i < 6; i++) host_write(6'(6'h32 + i), 8'(8'h11 * (i + 1)));
        model_read(1'b1, 6'h32, 6);
        bus_read(1'b1, 6'h32, 6, ok);
        n_cmp += 2;
        if (ok !== 1'b1) begin n_bad++; $display("FAIL burst_acks got %b want 1", ok); end
        if (oe_before_stop !== 1'b0) begin n_bad++; $display("FAIL burst_released got %b want 0", oe_before_stop); end
        foreach (erq[i]) begin
            n_cmp++;
            if (rq[i] !== erq[i]) begin n_bad++; $display("FAIL burst_byte_%0d got %h want %h", i, rq[i], erq[i]); end
        end
    endtask

    task automatic test_bad_addr();
        logic a;
        sq.delete();
        i2c_start();
        write_byte(8'h74, 1'b0, 6'd0, 8'd0, a);
        n_cmp += 3;
        if (a !== 1'b1)    begin n_bad++; $display("FAIL badaddr_ack got %b want 1", a); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL badaddr_busy got %b want 0", busy); end
        write_byte(8'h10, 1'b0, 6'd0, 8'd0, a);
        write_byte(8'h5A, 1'b0, 6'd0, 8'd0, a);
        i2c_stop();
        if (sq.size() != 0) begin n_bad++; $display("FAIL badaddr_strobes got %0d want 0", sq.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        host_write(6'h3F, 8'hA5);
        host_write(6'h01, 8'h5A);
        model_read(1'b1, 6'h3F, 3);
        bus_read(1'b1, 6'h3F, 3, ok);
        foreach (erq[i]) begin
            n_cmp++;
            if (rq[i] !== erq[i]) begin n_bad++; $display("FAIL wrap_byte_%0d got %h want %h", i, rq[i], erq[i]); end
        end
        wq = '{8'h77};
        model_write(6'h00);
        bus_write(6'h00, ok);
        n_cmp += 3;
        if (ok !== 1'b1)    begin n_bad++; $display("FAIL reg0_write_ack got %b want 1", ok); end
        if (sq.size() != 0) begin n_bad++; $display("FAIL reg0_strobes got %0d want 0", sq.size()); end
        model_read(1'b1, 6'h00, 1);
        bus_read(1'b1, 6'h00, 1, ok);
        if (rq[0] !== erq[0]) begin n_bad++; $display("FAIL reg0_devid got %h want %h", rq[0], erq[0]); end
    endtask

    task automatic test_collision();
        logic a;
        bit ok;
        sq.delete();
        i2c_start();
        write_byte(8'hA6, 1'b0, 6'd0, 8'd0, a);
        write_byte(8'h20, 1'b0, 6'd0, 8'd0, a);
        write_byte(8'h3C, 1'b1, 6'h20, 8'hC3, a);   // same address: bus wins
        write_byte(8'h4D, 1'b1, 6'h05, 8'h99, a);   // different: both land
        i2c_stop();
        mregs[6'h20] = 8'h3C;
        mregs[6'h05] = 8'h99;
        mregs[6'h21] = 8'h4D;
        mptr = 6'h22;
        model_read(1'b1, 6'h20, 2);
        bus_read(1'b1, 6'h20, 2, ok);
        foreach (erq[i]) begin
            n_cmp++;
            if (rq[i] !== erq[i]) begin n_bad++; $display("FAIL coll_byte_%0d got %h want %h", i, rq[i], erq[i]); end
        end
        model_read(1'b1, 6'h05, 1);
        bus_read(1'b1, 6'h05, 1, ok);
        n_cmp++;
        if (rq[0] !== erq[0]) begin n_bad++; $display("FAIL coll_host got %h want %h", rq[0], erq[0]); end
    endtask

    task automatic test_random();
        bit ok;
        logic [5:0] p;
        int n;
        for (int it = 0; it < 6; it++) begin
            host_write(6'($urandom_range(0, 63)), 8'($urandom));
            wq.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
            p = 6'($urandom_range(0, 63));
            model_write(p);
            bus_write(p, ok);
            n_cmp += 2;
            if (ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_wr_acks got %b want 1", it, ok); end
            if (sq.size() != esq.size()) begin
                n_bad++; $display("FAIL rnd%0d_strobe_count got %0d want %0d", it, sq.size(), esq.size());
            end else begin
                foreach (esq[i]) begin
                    n_cmp++;
                    if (sq[i] !== esq[i]) begin n_bad++; $display("FAIL rnd%0d_strobe_%0d got %h want %h", it, i, sq[i], esq[i]); end
                end
            end
            n = $urandom_range(1, 4);
            if (it % 2 == 0) begin
                p = 6'($urandom_range(0, 63));
                model_read(1'b1, p, n);
                bus_read(1'b1, p, n, ok);
            end else begin
                model_read(1'b0, 6'd0, n);
                bus_read(1'b0, 6'd0, n, ok);
            end
            n_cmp++;
            if (ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_rd_acks got %b want 1", it, ok); end
            foreach (erq[i]) begin
                n_cmp++;
                if (rq[i] !== erq[i]) begin n_bad++; $display("FAIL rnd%0d_rd_%0d got %h want %h", it, i, rq[i], erq[i]); end
            end
        end
    endtask

    task automatic test_stop_mid_byte();
        logic a;
        bit ok;
        i2c_start();
        write_byte(8'hA6, 1'b0, 6'd0, 8'd0, a);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        n_cmp += 3;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL stopmid_busy_before got %b want 1", busy); end
        i2c_stop();
        if (busy !== 1'b0) begin n_bad++; $display("FAIL stopmid_busy_after got %b want 0", busy); end
        model_read(1'b0, 6'd0, 1);
        bus_read(1'b0, 6'd0, 1, ok);
        if (rq[0] !== erq[0]) begin n_bad++; $display("FAIL stopmid_curread got %h want %h", rq[0], erq[0]); end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        host_write(6'h10, 8'h00);
        i2c_start();
        write_byte(8'hA6, 1'b0, 6'd0, 8'd0, a);
        write_byte(8'h10, 1'b0, 6'd0, 8'd0, a);
        i2c_start();
        write_byte(8'hA7, 1'b0, 6'd0, 8'd0, a);
        n_cmp += 3;
        if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL rstmid_driving got %b want 1", sda_oe); end
        reset = 1'b1;
        #1;
        if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rstmid_sda_oe got %b want 0", sda_oe); end
        if (busy !== 1'b0)   begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        m_scl = 1'b1; m_sda = 1'b1;
        wclk(3);
        reset = 1'b0;
        model_reset();
        wclk(5);
    endtask

    initial begin
        test_reset();
        test_devid_read();
        test_write_strobes();
        test_host_burst();
        test_bad_addr();
        test_wrap();
        test_collision();
        test_random();
        test_stop_mid_byte();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
